// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer/counter peripheral:
// default register addresses, control/status bit positions and FSM states.
package timer_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [10:0] DEF_TCR_ADDR   = 11'h407;
  localparam logic [10:0] DEF_TCNT_ADDR  = 11'h408;
  localparam logic [10:0] DEF_TCMP_ADDR  = 11'h409;
  localparam logic [10:0] DEF_TSR_ADDR   = 11'h40A;
  localparam logic [10:0] DEF_TDUTY_ADDR = 11'h40B;

  // TCR bit positions
  localparam int TCR_EN_BIT  = 0;
  localparam int TCR_AR_BIT  = 1;
  localparam int TCR_OS_BIT  = 2;
  localparam int TCR_PSC_LSB = 8;
  localparam int TCR_PSC_MSB = 15;

  // TSR bit positions
  localparam int TSR_MATCHF_BIT = 0;
  localparam int TSR_OVFF_BIT   = 1;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: pcnt runs 0..psc and emits a one-cycle tick on the
// terminal count. clr (any control write) restarts the count and masks the
// tick for that cycle; the counter idles at 0 while en is low.
module timer_prescaler (
  input  logic       clk,
  input  logic       rstB,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] psc,
  output logic       tick
);

  logic [7:0] pcnt;

  assign tick = en && !clr && (pcnt == psc);

  // Prescale counter: wraps on terminal count, cleared by clr or when idle.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      pcnt <= 8'd0;
    end else if (clr || !en || (pcnt == psc)) begin
      pcnt <= 8'd0;
    end else begin
      pcnt <= pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/timer_module.sv
// 32-bit timer/counter peripheral on the peripheral data bus.
// Registers: TCR (control), TCNT (counter), TCMP (compare), TSR (W1C status).
// Optional PWM output and TDUTY register are built when TIMER_PWM_EN is
// defined; otherwise pwm is tied low and TDUTY_ADDR is not decoded.
//
// Bus handshake: a write is applied at the clock edge where wrEn is high and
// addr decodes; a read with rdEn and a decoded addr returns dataOut with a
// one-cycle outEn strobe on the following cycle, carrying the register value
// as it was during the rdEn cycle. Undecoded accesses are ignored and leave
// dataOut unchanged.
module timer_module
  import timer_pkg::*;
#(
`ifdef TIMER_PWM_EN
  parameter logic [10:0] TDUTY_ADDR = DEF_TDUTY_ADDR,
`endif
  parameter logic [10:0] TCR_ADDR  = DEF_TCR_ADDR,
  parameter logic [10:0] TCNT_ADDR = DEF_TCNT_ADDR,
  parameter logic [10:0] TCMP_ADDR = DEF_TCMP_ADDR,
  parameter logic [10:0] TSR_ADDR  = DEF_TSR_ADDR,
  parameter int          XLEN      = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rstB,
  input  logic [10:0]     addr,
  input  logic [XLEN-1:0] wrData,
  input  logic            wrEn,
  input  logic            rdEn,
  output logic [XLEN-1:0] dataOut,
  output logic            outEn,
  output logic            matchPulse,
  output logic            pwm
);

  timer_state_t    state;
  logic            tcr_en;
  logic            tcr_ar;
  logic            tcr_os;
  logic [7:0]      tcr_psc;
  logic [XLEN-1:0] tcnt;
  logic [XLEN-1:0] tcmp;
  logic            matchf;
  logic            ovff;

  logic wr_tcr, wr_tcnt, wr_tcmp, wr_tsr;
  logic running, tick;
  logic match_hit, ovf_hit;
  logic rd_hit;
  logic [XLEN-1:0] rd_data;

  assign wr_tcr  = wrEn && (addr == TCR_ADDR);
  assign wr_tcnt = wrEn && (addr == TCNT_ADDR);
  assign wr_tcmp = wrEn && (addr == TCMP_ADDR);
  assign wr_tsr  = wrEn && (addr == TSR_ADDR);

  assign running = (state == RUN);

  timer_prescaler u_prescaler (
    .clk  (clk),
    .rstB (rstB),
    .clr  (wr_tcr),
    .en   (running),
    .psc  (tcr_psc),
    .tick (tick)
  );

  // A CPU write to TCNT pre-empts both increment and compare in that cycle.
  assign match_hit = tick && !wr_tcnt && (tcnt == tcmp);
  assign ovf_hit   = tick && !wr_tcnt && (tcnt == {XLEN{1'b1}}) && (tcnt != tcmp);

  // Control register and run-state FSM; one-shot match parks in DONE with EN cleared.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state   <= STOP;
      tcr_en  <= 1'b0;
      tcr_ar  <= 1'b0;
      tcr_os  <= 1'b0;
      tcr_psc <= 8'd0;
    end else begin
      if (wr_tcr) begin
        tcr_en  <= wrData[TCR_EN_BIT];
        tcr_ar  <= wrData[TCR_AR_BIT];
        tcr_os  <= wrData[TCR_OS_BIT];
        tcr_psc <= wrData[TCR_PSC_MSB:TCR_PSC_LSB];
      end
      case (state)
        STOP: if (wr_tcr && wrData[TCR_EN_BIT]) state <= RUN;
        RUN: begin
          if (wr_tcr && !wrData[TCR_EN_BIT]) begin
            state <= STOP;
          end else if (match_hit && tcr_os) begin
            state  <= DONE;
            tcr_en <= 1'b0;
          end
        end
        DONE: if (wr_tcr) state <= wrData[TCR_EN_BIT] ? RUN : STOP;
        default: state <= STOP;
      endcase
    end
  end

  // Counter, compare register and the registered match pulse.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      tcnt       <= '0;
      tcmp       <= '0;
      matchPulse <= 1'b0;
    end else begin
      matchPulse <= match_hit;
      if (wr_tcmp) tcmp <= wrData;
      if (wr_tcnt) begin
        tcnt <= wrData;
      end else if (match_hit) begin
        if (tcr_os)      tcnt <= tcnt;
        else if (tcr_ar) tcnt <= '0;
        else             tcnt <= tcnt + 1'b1;
      end else if (ovf_hit) begin
        tcnt <= '0;
      end else if (tick) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Status flags: write-1-to-clear, a same-cycle hardware set wins.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      matchf <= 1'b0;
      ovff   <= 1'b0;
    end else begin
      matchf <= (matchf && !(wr_tsr && wrData[TSR_MATCHF_BIT])) || match_hit;
      ovff   <= (ovff && !(wr_tsr && wrData[TSR_OVFF_BIT])) || ovf_hit;
    end
  end

`ifdef TIMER_PWM_EN
  logic            wr_tduty;
  logic [XLEN-1:0] tduty;

  assign wr_tduty = wrEn && (addr == TDUTY_ADDR);

  // Duty register and registered PWM compare against the running count.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      tduty <= '0;
      pwm   <= 1'b0;
    end else begin
      if (wr_tduty) tduty <= wrData;
      pwm <= tcr_en && (tcnt < tduty);
    end
  end
`else
  assign pwm = 1'b0;
`endif

  // Read decode: select the addressed register image.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (addr == TCR_ADDR) begin
      rd_hit                               = 1'b1;
      rd_data[TCR_EN_BIT]                  = tcr_en;
      rd_data[TCR_AR_BIT]                  = tcr_ar;
      rd_data[TCR_OS_BIT]                  = tcr_os;
      rd_data[TCR_PSC_MSB:TCR_PSC_LSB]     = tcr_psc;
    end else if (addr == TCNT_ADDR) begin
      rd_hit  = 1'b1;
      rd_data = tcnt;
    end else if (addr == TCMP_ADDR) begin
      rd_hit  = 1'b1;
      rd_data = tcmp;
    end else if (addr == TSR_ADDR) begin
      rd_hit                  = 1'b1;
      rd_data[TSR_MATCHF_BIT] = matchf;
      rd_data[TSR_OVFF_BIT]   = ovff;
    end
`ifdef TIMER_PWM_EN
    else if (addr == TDUTY_ADDR) begin
      rd_hit  = 1'b1;
      rd_data = tduty;
    end
`endif
  end

  // Registered read data and one-cycle valid strobe.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      dataOut <= '0;
      outEn   <= 1'b0;
    end else begin
      outEn <= rdEn && rd_hit;
      if (rdEn && rd_hit) dataOut <= rd_data;
    end
  end

endmodule

// File: tb/tb_timer_module.sv
// Directed self-checking bench for timer_module. Inputs change 1 time unit
// after the rising edge; outputs are sampled at the same point.
// Build with +define+TIMER_PWM_EN to exercise the PWM variant.
module tb_timer_module;

  localparam logic [10:0] A_TCR   = 11'h407;
  localparam logic [10:0] A_TCNT  = 11'h408;
  localparam logic [10:0] A_TCMP  = 11'h409;
  localparam logic [10:0] A_TSR   = 11'h40A;
  localparam logic [10:0] A_TDUTY = 11'h40B;
  localparam logic [10:0] A_NONE  = 11'h40C;

  logic        clk;
  logic        rstB;
  logic [10:0] addr;
  logic [31:0] wrData;
  logic        wrEn;
  logic        rdEn;
  logic [31:0] dataOut;
  logic        outEn;
  logic        matchPulse;
  logic        pwm;

  int checks = 0;
  int errors = 0;

  timer_module dut (
    .clk        (clk),
    .rstB       (rstB),
    .addr       (addr),
    .wrData     (wrData),
    .wrEn       (wrEn),
    .rdEn       (rdEn),
    .dataOut    (dataOut),
    .outEn      (outEn),
    .matchPulse (matchPulse),
    .pwm        (pwm)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: each spans exactly one rising edge
  task automatic bus_write(input logic [10:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  task automatic bus_read(input logic [10:0] a, output logic [31:0] d, output logic v);
    addr = a; rdEn = 1'b1;
    @(posedge clk); #1;
    rdEn = 1'b0;
    d = dataOut;
    v = outEn;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    checks++;
    if (dataOut !== 32'h0 || outEn !== 1'b0 || matchPulse !== 1'b0 || pwm !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got dataOut=%h outEn=%b match=%b pwm=%b exp all 0",
               dataOut, outEn, matchPulse, pwm);
    end
    bus_read(A_TCR, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL reset_tcr got v=%b d=%h exp v=1 d=0", v, d);
    end
    bus_read(A_TCNT, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL reset_tcnt got v=%b d=%h exp v=1 d=0", v, d);
    end
    bus_read(A_TSR, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL reset_tsr got v=%b d=%h exp v=1 d=0", v, d);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    logic v;
    bus_write(A_TCMP, 32'd5);
    bus_write(A_TCR, 32'h3);
    // read k observes the count before edge k+1: (k-1) mod 6; pulse follows the tick at 5
    for (int k = 1; k <= 12; k++) begin
      bus_read(A_TCNT, d, v);
      checks++;
      if (v !== 1'b1 || d !== 32'((k - 1) % 6)) begin
        errors++; $display("FAIL periodic_tcnt[%0d] got v=%b d=%0d exp v=1 d=%0d", k, v, d, (k - 1) % 6);
      end
      checks++;
      if (matchPulse !== ((k % 6) == 0)) begin
        errors++; $display("FAIL periodic_pulse[%0d] got %b exp %b", k, matchPulse, (k % 6) == 0);
      end
    end
    bus_read(A_TSR, d, v);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL periodic_tsr got %h exp 00000001", d);
    end
    bus_write(A_TCR, 32'h0);
    bus_write(A_TSR, 32'h3);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic v;
    int first_hit;
    int hits;
    first_hit = 0;
    hits = 0;
    bus_write(A_TCNT, 32'h0);
    bus_write(A_TCMP, 32'd2);
    bus_write(A_TCR, 32'h0000_0305);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (matchPulse === 1'b1) begin
        hits++;
        if (first_hit == 0) first_hit = i;
      end
    end
    checks++;
    if (first_hit != 12 || hits != 1) begin
      errors++; $display("FAIL oneshot_pulse got first=%0d hits=%0d exp first=12 hits=1", first_hit, hits);
    end
    bus_read(A_TCR, d, v);
    checks++;
    if (d !== 32'h0000_0304) begin
      errors++; $display("FAIL oneshot_tcr got %h exp 00000304", d);
    end
    bus_read(A_TCNT, d, v);
    checks++;
    if (d !== 32'd2) begin
      errors++; $display("FAIL oneshot_tcnt_hold got %0d exp 2", d);
    end
    bus_read(A_TSR, d, v);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL oneshot_tsr got %h exp 00000001", d);
    end
    bus_write(A_TCR, 32'h0);
    bus_write(A_TSR, 32'h3);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic v;
    bus_write(A_TCMP, 32'd100);
    bus_write(A_TCNT, 32'hFFFF_FFFE);
    bus_write(A_TCR, 32'h1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    // stopping write masks the tick of its own cycle, so the count stays at 0
    bus_write(A_TCR, 32'h0);
    bus_read(A_TCNT, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL ovf_wrap got %h exp 00000000", d);
    end
    bus_read(A_TSR, d, v);
    checks++;
    if (d !== 32'h2) begin
      errors++; $display("FAIL ovf_flag got %h exp 00000002", d);
    end
    bus_write(A_TSR, 32'h2);
    bus_read(A_TSR, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL ovf_clear got %h exp 00000000", d);
    end
  endtask

  task automatic test_w1c_race_and_read();
    logic [31:0] d;
    logic v;
    bus_write(A_TCMP, 32'd3);
    bus_write(A_TCNT, 32'd0);
    bus_write(A_TCR, 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    // count is 3 now; this W1C lands on the same edge as the match
    bus_write(A_TSR, 32'h1);
    checks++;
    if (matchPulse !== 1'b1) begin
      errors++; $display("FAIL race_pulse got %b exp 1", matchPulse);
    end
    bus_read(A_TSR, d, v);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL race_matchf got %h exp 00000001", d);
    end
    // CPU write to a running counter wins over the increment
    bus_write(A_TCNT, 32'd50);
    bus_read(A_TCNT, d, v);
    checks++;
    if (d !== 32'd50) begin
      errors++; $display("FAIL tcnt_write_wins got %0d exp 50", d);
    end
    bus_read(A_TCMP, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'd3) begin
      errors++; $display("FAIL read_tcmp got v=%b d=%0d exp v=1 d=3", v, d);
    end
    @(posedge clk); #1;
    checks++;
    if (outEn !== 1'b0) begin
      errors++; $display("FAIL outen_one_cycle got %b exp 0", outEn);
    end
    bus_write(A_NONE, 32'hFFFF_FFFF);
    bus_read(A_NONE, d, v);
    checks++;
    if (v !== 1'b0 || d !== 32'd3) begin
      errors++; $display("FAIL unmapped_read got v=%b d=%h exp v=0 d=00000003", v, d);
    end
    bus_read(A_TCMP, d, v);
    checks++;
    if (d !== 32'd3) begin
      errors++; $display("FAIL unmapped_write got %h exp 00000003", d);
    end
    bus_write(A_TCR, 32'h0);
    bus_write(A_TSR, 32'h3);
  endtask

  task automatic test_pwm();
    logic [31:0] d;
    logic v;
    int highs;
    logic exp_pwm;
    highs = 0;
    bus_write(A_TCNT, 32'd0);
    bus_write(A_TCMP, 32'd9);
    bus_write(A_TDUTY, 32'd3);
    bus_write(A_TCR, 32'h3);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
`ifdef TIMER_PWM_EN
      exp_pwm = (((k - 1) % 10) < 3);
`else
      exp_pwm = 1'b0;
`endif
      if (pwm === 1'b1) highs++;
      checks++;
      if (pwm !== exp_pwm) begin
        errors++; $display("FAIL pwm[%0d] got %b exp %b", k, pwm, exp_pwm);
      end
    end
    bus_write(A_TCR, 32'h0);
    bus_read(A_TDUTY, d, v);
`ifdef TIMER_PWM_EN
    checks++;
    if (highs != 6) begin
      errors++; $display("FAIL pwm_highs got %0d exp 6", highs);
    end
    checks++;
    if (v !== 1'b1 || d !== 32'd3) begin
      errors++; $display("FAIL tduty_read got v=%b d=%0d exp v=1 d=3", v, d);
    end
`else
    checks++;
    if (v !== 1'b0) begin
      errors++; $display("FAIL tduty_absent got outEn=%b exp 0", v);
    end
`endif
    bus_write(A_TSR, 32'h3);
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    logic v;
    bus_write(A_TCNT, 32'd0);
    bus_write(A_TCMP, 32'd37);
    bus_write(A_TCR, 32'h3);
    repeat (36) @(posedge clk);
    #1;
    bus_read(A_TCNT, d, v);
    checks++;
    if (v !== 1'b1 || d !== 32'd36) begin
      errors++; $display("FAIL pre_reset_read got v=%b d=%0d exp v=1 d=36", v, d);
    end
    // count is 37 and a match is one tick away
    rstB = 1'b0;
    #1;
    checks++;
    if (dataOut !== 32'h0 || outEn !== 1'b0 || matchPulse !== 1'b0 || pwm !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got dataOut=%h outEn=%b match=%b pwm=%b exp all 0",
               dataOut, outEn, matchPulse, pwm);
    end
    repeat (2) @(posedge clk);
    #1;
    rstB = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (matchPulse !== 1'b0) begin
        errors++; $display("FAIL post_reset_pulse[%0d] got %b exp 0", i, matchPulse);
      end
    end
    bus_read(A_TCNT, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL post_reset_tcnt got %h exp 00000000", d);
    end
    bus_read(A_TCMP, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL post_reset_tcmp got %h exp 00000000", d);
    end
    bus_read(A_TCR, d, v);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL post_reset_tcr got %h exp 00000000", d);
    end
  endtask

  // Reset sequence, scenario tasks, final report
  initial begin
    rstB   = 1'b0;
    addr   = 11'h0;
    wrData = 32'h0;
    wrEn   = 1'b0;
    rdEn   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstB = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_periodic();
    test_oneshot();
    test_overflow();
    test_w1c_race_and_read();
    test_pwm();
    test_reset_mid_count();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
